// File: rtl/sseg_frame_decoder.sv
// Seven-segment bus reader: samples the multiplexed 4-digit scan, decodes it and publishes stable frames.
// Optional macro SSEG_DEC_BIN_EN adds bin_val/bcd_err (binary value of the published BCD digits).
module sseg_frame_decoder #(
  parameter int SETTLE_CYC    = 16,
  parameter int STABLE_FRAMES = 2,
  parameter int TIMEOUT_CYC   = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  an,
  input  logic [7:0]  sseg,
  output logic [15:0] digit_val,
  output logic [3:0]  digit_blank,
  output logic [3:0]  digit_dp,
  output logic [3:0]  digit_bad,
  output logic        valid,
  output logic        update,
  output logic        dark
`ifdef SSEG_DEC_BIN_EN
  ,
  output logic [13:0] bin_val,
  output logic        bcd_err
`endif
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int MW = $clog2(STABLE_FRAMES + 1);
  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  typedef struct packed {
    logic       bad;
    logic       dp;
    logic       blank;
    logic [3:0] nib;
  } slot_t;

  function automatic slot_t decode_seg(input logic [7:0] seg);
    slot_t s;
    s       = '0;
    s.dp    = ~seg[7];
    case (seg[6:0])
      7'h40:   s.nib = 4'h0;
      7'h79:   s.nib = 4'h1;
      7'h24:   s.nib = 4'h2;
      7'h30:   s.nib = 4'h3;
      7'h19:   s.nib = 4'h4;
      7'h12:   s.nib = 4'h5;
      7'h02:   s.nib = 4'h6;
      7'h78:   s.nib = 4'h7;
      7'h00:   s.nib = 4'h8;
      7'h10:   s.nib = 4'h9;
      7'h08:   s.nib = 4'hA;
      7'h03:   s.nib = 4'hB;
      7'h46:   s.nib = 4'hC;
      7'h21:   s.nib = 4'hD;
      7'h06:   s.nib = 4'hE;
      7'h0E:   s.nib = 4'hF;
      7'h7F:   s.blank = 1'b1;
      default: s.bad = 1'b1;
    endcase
    return s;
  endfunction

`ifdef SSEG_DEC_BIN_EN
  function automatic logic [13:0] frame_to_bin(input slot_t [3:0] f);
    logic [13:0] acc;
    acc = 14'd0;
    for (int i = 3; i >= 0; i--) begin
      acc = (acc * 14'd10) + {10'd0, f[i].nib};
    end
    return acc;
  endfunction

  function automatic logic frame_bcd_err(input slot_t [3:0] f);
    logic err;
    err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      err = err | (f[i].nib > 4'd9) | f[i].blank | f[i].bad;
    end
    return err;
  endfunction
`endif

  logic [3:0]    an_q_r, an_prev_r;
  logic [7:0]    sseg_q_r, sseg_prev_r;
  logic [SW-1:0] settle_cnt_r;
  logic          captured_r;
  logic [IW-1:0] idle_cnt_r;
  logic [3:0]    seen_r, seen_nxt_s;
  logic [MW-1:0] match_cnt_r;
  slot_t [3:0]   frame_r, cand_r, pub_r;
  logic          valid_r, update_r, dark_r;
  logic          sel_valid_s, change_s, capture_s, complete_s, timeout_s, publish_s;
  logic [1:0]    sel_idx_s;
  slot_t         dec_s;
  logic          unused_s;

  assign unused_s = ^an[7:4];

  // Select decode: exactly one low enable in an[3:0] names the digit, anything else is idle.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = 2'd0;
    case (an_q_r)
      4'b1110: begin sel_valid_s = 1'b1; sel_idx_s = 2'd0; end
      4'b1101: begin sel_valid_s = 1'b1; sel_idx_s = 2'd1; end
      4'b1011: begin sel_valid_s = 1'b1; sel_idx_s = 2'd2; end
      4'b0111: begin sel_valid_s = 1'b1; sel_idx_s = 2'd3; end
      default: sel_valid_s = 1'b0;
    endcase
  end

  // Per-cycle events derived from the registered bus copies and counters.
  always_comb begin
    change_s   = (an_q_r != an_prev_r) || (sseg_q_r != sseg_prev_r);
    capture_s  = sel_valid_s && !change_s && !captured_r &&
                 (settle_cnt_r == SW'(SETTLE_CYC - 1));
    complete_s = (seen_r == 4'b1111);
    timeout_s  = !sel_valid_s && (idle_cnt_r == IW'(TIMEOUT_CYC - 1));
    publish_s  = (match_cnt_r == MW'(STABLE_FRAMES)) && (!valid_r || (cand_r != pub_r));
    dec_s      = decode_seg(sseg_q_r);
  end

  // Seen mask: cleared on frame completion or timeout, a same-cycle capture lands in the new mask.
  always_comb begin
    seen_nxt_s = seen_r;
    if (timeout_s || complete_s) begin
      seen_nxt_s = 4'b0000;
    end else begin
      seen_nxt_s = seen_r;
    end
    if (capture_s) begin
      seen_nxt_s[sel_idx_s] = 1'b1;
    end else begin
      seen_nxt_s = seen_nxt_s;
    end
  end

  // Input stage, settle counter (one capture per dwell) and idle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_q_r       <= 4'h0;
      an_prev_r    <= 4'h0;
      sseg_q_r     <= 8'h00;
      sseg_prev_r  <= 8'h00;
      settle_cnt_r <= '0;
      captured_r   <= 1'b0;
      idle_cnt_r   <= '0;
    end else begin
      an_q_r      <= an[3:0];
      an_prev_r   <= an_q_r;
      sseg_q_r    <= sseg;
      sseg_prev_r <= sseg_q_r;
      if (change_s || !sel_valid_s) begin
        settle_cnt_r <= '0;
        captured_r   <= 1'b0;
      end else begin
        if (settle_cnt_r != SW'(SETTLE_CYC - 1)) settle_cnt_r <= settle_cnt_r + SW'(1);
        if (capture_s) captured_r <= 1'b1;
      end
      if (sel_valid_s) begin
        idle_cnt_r <= '0;
      end else if (idle_cnt_r != IW'(TIMEOUT_CYC)) begin
        idle_cnt_r <= idle_cnt_r + IW'(1);
      end else begin
        idle_cnt_r <= idle_cnt_r;
      end
    end
  end

  // Frame buffer, candidate frame and consecutive-match counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_r     <= '0;
      cand_r      <= '0;
      seen_r      <= 4'b0000;
      match_cnt_r <= '0;
    end else begin
      seen_r <= seen_nxt_s;
      if (capture_s) frame_r[sel_idx_s] <= dec_s;
      if (timeout_s) begin
        match_cnt_r <= '0;
      end else if (complete_s) begin
        if (frame_r == cand_r) begin
          if (match_cnt_r != MW'(STABLE_FRAMES)) match_cnt_r <= match_cnt_r + MW'(1);
        end else begin
          cand_r      <= frame_r;
          match_cnt_r <= MW'(1);
        end
      end else begin
        match_cnt_r <= match_cnt_r;
      end
    end
  end

  // Published outputs; a republished identical frame sets valid without an update pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pub_r    <= '0;
      valid_r  <= 1'b0;
      update_r <= 1'b0;
      dark_r   <= 1'b0;
    end else begin
      update_r <= 1'b0;
      if (timeout_s) begin
        dark_r  <= 1'b1;
        valid_r <= 1'b0;
      end else if (publish_s) begin
        pub_r    <= cand_r;
        valid_r  <= 1'b1;
        update_r <= (cand_r != pub_r);
      end else begin
        valid_r <= valid_r;
      end
      if (capture_s) dark_r <= 1'b0;
    end
  end

`ifdef SSEG_DEC_BIN_EN
  logic [13:0] bin_val_r;
  logic        bcd_err_r;

  // Binary conversion registered alongside the publish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_val_r <= 14'd0;
      bcd_err_r <= 1'b0;
    end else if (publish_s && !timeout_s) begin
      bcd_err_r <= frame_bcd_err(cand_r);
      bin_val_r <= frame_bcd_err(cand_r) ? 14'd0 : frame_to_bin(cand_r);
    end else begin
      bin_val_r <= bin_val_r;
    end
  end

  assign bin_val = bin_val_r;
  assign bcd_err = bcd_err_r;
`endif

  assign digit_val   = {pub_r[3].nib, pub_r[2].nib, pub_r[1].nib, pub_r[0].nib};
  assign digit_blank = {pub_r[3].blank, pub_r[2].blank, pub_r[1].blank, pub_r[0].blank};
  assign digit_dp    = {pub_r[3].dp, pub_r[2].dp, pub_r[1].dp, pub_r[0].dp};
  assign digit_bad   = {pub_r[3].bad, pub_r[2].bad, pub_r[1].bad, pub_r[0].bad};
  assign valid       = valid_r;
  assign update      = update_r;
  assign dark        = dark_r;

endmodule

// File: tb/tb_sseg_frame_decoder.sv
// Directed self-checking bench for sseg_frame_decoder (TIMEOUT_CYC reduced to 256).
module tb_sseg_frame_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  an;
  logic [7:0]  sseg;
  logic [15:0] digit_val;
  logic [3:0]  digit_blank, digit_dp, digit_bad;
  logic        valid, update, dark;
`ifdef SSEG_DEC_BIN_EN
  logic [13:0] bin_val;
  logic        bcd_err;
`endif

  int tests = 0;
  int fails = 0;
  int upd_cnt = 0;
  int upd_base = 0;

  always #5 clk = ~clk;

  sseg_frame_decoder #(
    .SETTLE_CYC(16), .STABLE_FRAMES(2), .TIMEOUT_CYC(256)
  ) dut (
    .clk(clk), .reset(reset), .an(an), .sseg(sseg),
    .digit_val(digit_val), .digit_blank(digit_blank), .digit_dp(digit_dp),
    .digit_bad(digit_bad), .valid(valid), .update(update), .dark(dark)
`ifdef SSEG_DEC_BIN_EN
    , .bin_val(bin_val), .bcd_err(bcd_err)
`endif
  );

  always @(negedge clk) begin
    if (update === 1'b1) upd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: seg_of = 8'hC0;  4'h1: seg_of = 8'hF9;  4'h2: seg_of = 8'hA4;  4'h3: seg_of = 8'hB0;
      4'h4: seg_of = 8'h99;  4'h5: seg_of = 8'h92;  4'h6: seg_of = 8'h82;  4'h7: seg_of = 8'hF8;
      4'h8: seg_of = 8'h80;  4'h9: seg_of = 8'h90;  4'hA: seg_of = 8'h88;  4'hB: seg_of = 8'h83;
      4'hC: seg_of = 8'hC6;  4'hD: seg_of = 8'hA1;  4'hE: seg_of = 8'h86;  default: seg_of = 8'h8E;
    endcase
  endfunction

  task automatic show(input int d, input logic [7:0] s, input bit glitch);
    an    = 8'hFF;
    an[d] = 1'b0;
    if (glitch) begin
      sseg = 8'h80;
      repeat (5) @(negedge clk);
    end
    sseg = s;
    repeat (40) @(negedge clk);
  endtask

  task automatic scan_raw(input logic [7:0] s3, input logic [7:0] s2, input logic [7:0] s1,
                          input logic [7:0] s0, input int frames, input bit glitch);
    for (int f = 0; f < frames; f++) begin
      show(3, s3, glitch);
      show(2, s2, glitch);
      show(1, s1, glitch);
      show(0, s0, glitch);
    end
  endtask

  task automatic scan(input logic [15:0] hex, input int frames, input bit glitch);
    scan_raw(seg_of(hex[15:12]), seg_of(hex[11:8]), seg_of(hex[7:4]), seg_of(hex[3:0]),
             frames, glitch);
  endtask

  initial begin
    reset = 1'b1;
    an    = 8'hFF;
    sseg  = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_val", 32'(digit_val), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_dark", 32'(dark), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Stable "9999": not published after one frame, published once after two.
    upd_base = upd_cnt;
    scan(16'h9999, 1, 1'b0);
    chk("9999_f1_valid", 32'(valid), 32'h0);
    scan(16'h9999, 1, 1'b0);
    chk("9999_valid", 32'(valid), 32'h1);
    chk("9999_val", 32'(digit_val), 32'h9999);
    chk("9999_upd", 32'(upd_cnt - upd_base), 32'd1);
`ifdef SSEG_DEC_BIN_EN
    chk("9999_bin", 32'(bin_val), 32'd9999);
    chk("9999_bcderr", 32'(bcd_err), 32'h0);
`endif

    // "1000" then "0234": two publishes.
    upd_base = upd_cnt;
    scan(16'h1000, 2, 1'b0);
    chk("1000_val", 32'(digit_val), 32'h1000);
    scan(16'h0234, 2, 1'b0);
    chk("0234_val", 32'(digit_val), 32'h0234);
    chk("0234_blank", 32'(digit_blank), 32'h0);
    chk("0234_upd", 32'(upd_cnt - upd_base), 32'd2);

    // Short 8-pattern glitch at every select edge must never be captured.
    scan(16'h0512, 2, 1'b1);
    chk("glitch_val", 32'(digit_val), 32'h0512);
    chk("glitch_bad", 32'(digit_bad), 32'h0);
    chk("glitch_valid", 32'(valid), 32'h1);

    // Idle bus: dark just after 256 idle cycles, published digits held.
    an = 8'hFF;
    repeat (250) @(negedge clk);
    chk("idle250_dark", 32'(dark), 32'h0);
    repeat (12) @(negedge clk);
    chk("timeout_dark", 32'(dark), 32'h1);
    chk("timeout_valid", 32'(valid), 32'h0);
    chk("timeout_hold", 32'(digit_val), 32'h0512);
    show(3, seg_of(4'h0), 1'b0);
    chk("resume_dark", 32'(dark), 32'h0);
    show(2, seg_of(4'h0), 1'b0);
    show(1, seg_of(4'h4), 1'b0);
    show(0, seg_of(4'h2), 1'b0);
    scan(16'h0042, 1, 1'b0);
    chk("resume_valid", 32'(valid), 32'h1);
    chk("resume_val", 32'(digit_val), 32'h0042);

    // Reset mid-frame clears everything at once.
    show(3, seg_of(4'h7), 1'b0);
    show(2, seg_of(4'h7), 1'b0);
    upd_base = upd_cnt;
    reset = 1'b1;
    #1;
    chk("midrst_val", 32'(digit_val), 32'h0);
    chk("midrst_valid", 32'(valid), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Alternating frames never reach two consecutive matches.
    scan(16'h0001, 1, 1'b0);
    scan(16'h0002, 1, 1'b0);
    scan(16'h0001, 1, 1'b0);
    scan(16'h0002, 1, 1'b0);
    chk("alt_valid", 32'(valid), 32'h0);
    chk("alt_upd", 32'(upd_cnt - upd_base), 32'd0);

    // Blank digits 3,2, unknown 55 on digit 1, "0" with dp lit on digit 0.
    upd_base = upd_cnt;
    scan_raw(8'hFF, 8'hFF, 8'hD5, 8'h40, 2, 1'b0);
    chk("blank_flags", 32'(digit_blank), 32'hC);
    chk("bad_flags", 32'(digit_bad), 32'h2);
    chk("dp_flags", 32'(digit_dp), 32'h1);
    chk("bb_val", 32'(digit_val), 32'h0);
    chk("bb_valid", 32'(valid), 32'h1);
    chk("bb_upd", 32'(upd_cnt - upd_base), 32'd1);
`ifdef SSEG_DEC_BIN_EN
    chk("bb_bcderr", 32'(bcd_err), 32'h1);
    chk("bb_bin", 32'(bin_val), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
